// File: rtl/cmd_frame_parser_pkg.sv
// Shared constants for the FX2 command channel: sync byte, parser states
// and the register-file address map.
package timetag_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_LEN   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_ISSUE = 3'd4
  } cmd_state_t;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_SEQ    = 8'h01;
  localparam logic [7:0] REG_DET    = 8'h02;
  localparam logic [7:0] REG_PGEN   = 8'h04;
  localparam logic [7:0] REG_TDELAY = 8'h05;

endpackage

// File: rtl/cmd_frame_parser_if.sv
// Byte-stream input and register-write handshake of the command parser.
// master is the parser side; slave is the FIFO reader / register file side.
interface cmd_frame_parser_if #(
  parameter int DATA_BYTES = 4
);
  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              reg_addr;
  logic [8*DATA_BYTES-1:0] reg_data;
  logic                    reg_wr;
  logic                    reg_ack;

  modport master (
    input  in_data, in_valid, reg_ack,
    output in_ready, reg_addr, reg_data, reg_wr
  );

  modport slave (
    output in_data, in_valid, reg_ack,
    input  in_ready, reg_addr, reg_data, reg_wr
  );
endinterface

// File: rtl/cmd_frame_parser_watchdog.sv
// Idle counter for in-frame byte gaps: expired pulses once TIMEOUT-1 idle
// cycles have been counted; clear (a byte) always wins over expiry.
module frame_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = enable && !clear && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || !enable || expired) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cmd_frame_parser.sv
// Sync-hunting command frame parser: AA, LEN, ADDR, LEN data bytes -> one
// register write. Bad lengths and stalled frames are dropped and counted.
import timetag_cmd_pkg::*;

module cmd_frame_parser #(
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  cmd_frame_parser_if.master bus,
  output logic               busy,
  output logic [7:0]         err_count
);

  localparam int DW = 8 * DATA_BYTES;

  cmd_state_t    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    err_q, err_d;
  logic [DW-1:0] data_q, data_d;
  logic          in_ready_q, in_ready_d;
  logic          reg_wr_q, reg_wr_d;
  logic          fire, wd_enable, wd_expired, err_inc;

  assign fire      = bus.in_valid && in_ready_q;
  assign wd_enable = (state_q == ST_LEN) || (state_q == ST_ADDR) || (state_q == ST_DATA);

  frame_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (fire),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    err_inc = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (fire && bus.in_data == SYNC_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (fire) begin
          if (bus.in_data == 8'd0 || bus.in_data > 8'(DATA_BYTES)) begin
            state_d = ST_HUNT;
            err_inc = 1'b1;
          end else begin
            len_d   = bus.in_data;
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (fire) begin
          addr_d  = bus.in_data;
          data_d  = '0;
          idx_d   = 8'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fire) begin
          for (int k = 0; k < DATA_BYTES; k++) begin
            if (idx_q == 8'(k)) data_d[8*k +: 8] = bus.in_data;
          end
          idx_d = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.reg_ack) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase

    // Expiry is already suppressed by the watchdog when a byte lands this cycle.
    if (wd_expired) begin
      state_d = ST_HUNT;
      err_inc = 1'b1;
    end
    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;

    in_ready_d = (state_d != ST_ISSUE);
    reg_wr_d   = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HUNT;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      addr_q     <= 8'd0;
      data_q     <= '0;
      err_q      <= 8'd0;
      in_ready_q <= 1'b1;
      reg_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      reg_wr_q   <= reg_wr_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.reg_wr   = reg_wr_q;
  assign bus.reg_addr = addr_q;
  assign bus.reg_data = data_q;
  assign busy         = (state_q != ST_HUNT);
  assign err_count    = err_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: table of whole frames plus hand-written
// stall, timeout race, backpressure, saturation and mid-frame reset sequences.
module tb_cmd_frame_parser;
  import timetag_cmd_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       busy;
  logic [7:0] err_count;

  cmd_frame_parser_if #(.DATA_BYTES(4)) bus ();

  cmd_frame_parser #(.DATA_BYTES(4), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          wr_cnt = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [31:0] last_data = 32'h0;

  always @(posedge clk) begin
    if (reset_n && bus.reg_wr && bus.reg_ack) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= bus.reg_addr;
      last_data <= bus.reg_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      check("in_ready_wait", 32'(got), 32'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [95:0] bytes;
    int          n;
    int          exp_wr;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vec_t v;
    int   base;
    bit   bad;

    vecs[0] = '{96'hAA_02_05_40_02,             5,  1, 8'h05, 32'h0000_0240, 8'd0};
    vecs[1] = '{96'hFF_FF_13_AA_04_04_00_00_40_02, 10, 1, 8'h04, 32'h0240_0000, 8'd0};
    vecs[2] = '{96'hAA_00_AA_07,                4,  0, 8'h04, 32'h0240_0000, 8'd2};
    vecs[3] = '{96'hAA_01_01_01,                4,  1, 8'h01, 32'h0000_0001, 8'd2};
    vecs[4] = '{96'hAA_03_AA_11_AA_22,          6,  1, 8'hAA, 32'h0022_AA11, 8'd2};
    vecs[5] = '{96'hAA_05,                      2,  0, 8'hAA, 32'h0022_AA11, 8'd3};
    vecs[6] = '{96'hAA_04_10_01_02_03_04,       7,  1, 8'h10, 32'h0403_0201, 8'd3};

    reset_n      = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.reg_ack  = 1'b1;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_reg_wr",   32'(bus.reg_wr),   32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_addr",     32'(bus.reg_addr), 32'd0);
    check("rst_data",     bus.reg_data,      32'd0);
    check("rst_err",      32'(err_count),    32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      v    = vecs[i];
      base = wr_cnt;
      for (int j = 0; j < v.n; j++) send_byte(v.bytes[8*(v.n-1-j) +: 8]);
      settle();
      check($sformatf("v%0d_wr",   i), 32'(wr_cnt - base), 32'(v.exp_wr));
      check($sformatf("v%0d_addr", i), 32'(last_addr),     32'(v.exp_addr));
      check($sformatf("v%0d_data", i), last_data,          v.exp_data);
      check($sformatf("v%0d_err",  i), 32'(err_count),     32'(v.exp_err));
    end

    // Stall in DATA: still busy one cycle before the limit, abandoned at it.
    base = wr_cnt;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("stall_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("stall_busy_after", 32'(busy),      32'd0);
    check("stall_err",        32'(err_count), 32'd4);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03); send_byte(8'h07);
    settle();
    check("stall_wr",   32'(wr_cnt - base), 32'd1);
    check("stall_addr", 32'(last_addr),     32'h03);
    check("stall_data", last_data,          32'h07);

    // Byte arriving on the expiry cycle completes the frame.
    base = wr_cnt;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(8'h09);
    settle();
    check("race_wr",   32'(wr_cnt - base), 32'd1);
    check("race_data", last_data,          32'h09);
    check("race_err",  32'(err_count),     32'd4);

    // Backpressure: ack withheld 20 cycles while the next frame is offered.
    base = wr_cnt;
    bus.reg_ack = 1'b0;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h20); send_byte(8'h34); send_byte(8'h12);
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.reg_wr !== 1'b1 ||
          bus.reg_addr !== 8'h20 || bus.reg_data !== 32'h1234) bad = 1'b1;
    end
    check("bp_hold",   32'(bad),           32'd0);
    check("bp_no_wr",  32'(wr_cnt - base), 32'd0);
    bus.reg_ack = 1'b1;
    @(posedge clk);
    #1;
    check("bp_wr_fall",  32'(bus.reg_wr),   32'd0);
    check("bp_rdy_rise", 32'(bus.in_ready), 32'd1);
    check("bp_wr1",      32'(wr_cnt - base), 32'd1);
    check("bp_addr1",    32'(last_addr),     32'h20);
    check("bp_data1",    last_data,          32'h1234);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h30); send_byte(8'h55);
    settle();
    check("bp_wr2",   32'(wr_cnt - base), 32'd2);
    check("bp_addr2", 32'(last_addr),     32'h30);
    check("bp_data2", last_data,          32'h55);

    // Error counter saturation.
    for (int s = 0; s < 256; s++) begin
      send_byte(8'hAA);
      send_byte(8'h00);
    end
    settle();
    check("err_saturate", 32'(err_count), 32'd255);

    // Asynchronous reset mid-DATA.
    base = wr_cnt;
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h04); send_byte(8'h00);
    check("mid_busy", 32'(busy),         32'd1);
    check("mid_addr", 32'(bus.reg_addr), 32'h04);
    reset_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_reg_wr",   32'(bus.reg_wr),   32'd0);
    check("arst_busy",     32'(busy),         32'd0);
    check("arst_addr",     32'(bus.reg_addr), 32'd0);
    check("arst_data",     bus.reg_data,      32'd0);
    check("arst_err",      32'(err_count),    32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    settle();
    check("arst_no_wr", 32'(wr_cnt - base), 32'd0);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h02);
    settle();
    check("post_rst_wr",   32'(wr_cnt - base), 32'd1);
    check("post_rst_addr", 32'(last_addr),     32'h02);
    check("post_rst_data", last_data,          32'h02);
    check("post_rst_err",  32'(err_count),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Byte-stream command parser between the FX2 OUT-endpoint FIFO reader and the timetagger register file. It hunts for the sync byte, collects a length/address/data frame, and issues exactly one register-write handshake per valid frame. Malformed, oversized and stalled frames are discarded and counted, so host-side garbage never reaches the sequencer, detector or pulse-generator configuration.

## Interface
- `DATA_BYTES`, 4: maximum payload bytes per frame; `reg_data` width is 8*DATA_BYTES.
- `TIMEOUT`, 1024: idle cycles allowed between bytes inside a frame before it is abandoned; must be ≥2.
- `clk` in 1: single clock; `fx2_clk` domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: parser accepts a byte this cycle.
- `reg_addr` out 8: target register address.
- `reg_data` out 8*DATA_BYTES: write value, little-endian assembled.
- `reg_wr` out 1: write request, held until acknowledged.
- `reg_ack` in 1: register file accepts the write.
- `busy` out 1: high in any state other than HUNT.
- `err_count` out 8: saturating count of discarded frames.

## Operation
- Frame format: 0xAA, LEN, ADDR, then LEN data bytes. LEN valid range is 1..DATA_BYTES.
- States: HUNT, LEN, ADDR, DATA, ISSUE.
- HUNT: accept bytes; 0xAA → LEN; any other byte dropped silently, with no error count.
- LEN: 0 or >DATA_BYTES → HUNT, err_count+1. Otherwise latch LEN → ADDR.
- ADDR: latch `reg_addr`; clear `reg_data` to zero; → DATA.
- DATA: byte k (0-based) is written to `reg_data[8k+7:8k]`. Upper unused bytes stay zero. After byte LEN-1 → ISSUE.
- ISSUE: `in_ready`=0, `reg_wr`=1. `reg_addr`/`reg_data` stay stable until `reg_ack` is sampled high, then → HUNT.
- An 0xAA received in LEN/ADDR/DATA is ordinary data, not a resync.
- Timeout: a counter clears on every accepted byte and on entry to LEN. In LEN/ADDR/DATA, reaching TIMEOUT-1 idle cycles → HUNT, err_count+1, partial frame discarded. ISSUE has no timeout.
- `err_count` saturates at 255 and never wraps.

## Timing
- A byte transfers on a rising edge where `in_valid && in_ready`.
- `in_ready` = 1 in HUNT/LEN/ADDR/DATA and 0 in ISSUE. It is registered from state, so there is no combinational path from `in_valid`.
- Latency: `reg_wr` rises the cycle after the last data byte transfers.
- `reg_wr` falls the cycle after `reg_ack`=1 is sampled; `in_ready` returns high in that same cycle.
- Minimum frame-to-frame spacing: one ISSUE cycle plus the ack wait.
- `reg_ack` while `reg_wr`=0 is ignored.
- Reset values: state HUNT; `in_ready`=1, `reg_wr`=0, `busy`=0, `reg_addr`=0, `reg_data`=0, `err_count`=0, timeout counter 0.
- Reset asserted mid-frame or mid-ISSUE: all outputs go to reset values immediately (asynchronous) and the partial frame is lost, uncounted.
- A timeout and a byte arriving on the same cycle: the byte wins and the counter clears.
- Back-to-back frames with `in_valid` held high and `reg_ack` tied high: no bytes are lost.

## Structure
- Package `timetag_cmd_pkg` contains:
  - `SYNC_BYTE` = 8'hAA;
  - the state enum `cmd_state_t`;
  - the register address constants shared with the register file.
- One sub-module, `frame_watchdog`: TIMEOUT-parameterised idle counter with `clear`, `enable` and a `expired` pulse output.
- Everything else lives in a single FSM plus datapath registers.

## Test plan
- Write, 2 data bytes: AA 02 05 40 02, `reg_ack` tied high → one `reg_wr` pulse with addr 0x05, data 0x00000240, err_count 0.
- Leading trash, 4 data bytes: FF FF 13 AA 04 04 00 00 40 02 → addr 0x04, data 0x02400000, err_count 0; the leading trash is not counted.
- Bad length: AA 00 then AA 07 → no `reg_wr`, err_count=2. A following AA 01 01 01 → write addr 0x01, data 0x00000001.
- Stall: AA 01 02, then idle for TIMEOUT cycles → parser returns to HUNT, err_count+1, no write. The next complete frame is accepted.
- Backpressure: hold `reg_ack` low for 20 cycles during ISSUE while pushing the next frame → `in_ready`=0 throughout and addr/data stable. The write completes, and the second frame then writes correctly.
- Reset mid-DATA: pulse `reset_n` low after AA 04 04 00 → `reg_wr` never asserts, all outputs at reset values. A fresh AA 01 02 02 → write addr 0x02, data 0x00000002.
